// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared constants and types for the registered demultiplexer.
//   SEL_W_DEF  : default select width
//   DATA_W_DEF : default data width per output lane
//   n_out()    : number of output lanes for a given select width
//   sel_t      : lane index at the default select width
// Optional feature macro used by the top level: DEMUX_HOLD_EN.
// -----------------------------------------------------------------------------
package demux_pkg;

   localparam int SEL_W_DEF  = 2;
   localparam int DATA_W_DEF = 1;

   // Every select code addresses a lane, so there is no out-of-range select.
   function automatic int n_out(input int sel_w);
      return 1 << sel_w;
   endfunction

   localparam int N_OUT_DEF = n_out(SEL_W_DEF);

   typedef logic [SEL_W_DEF-1:0] sel_t;

endpackage

// File: rtl/demux_if.sv
// -----------------------------------------------------------------------------
// demux_if
// Bus bundle between a driver and the demultiplexer.
//   Y : data to route                 (DATA_W bits)
//   S : binary lane select            (SEL_W bits)
//   E : enable, active-high
//   I : output lanes, lane k at [k*DATA_W +: DATA_W]
// Modports: master drives Y/S/E and observes I; slave is the demultiplexer.
// -----------------------------------------------------------------------------
interface demux_if
   import demux_pkg::*;
#(
   parameter int SEL_W  = SEL_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   localparam int N_OUT = n_out(SEL_W);

   logic [DATA_W-1:0]       Y;
   logic [SEL_W-1:0]        S;
   logic                    E;
   logic [N_OUT*DATA_W-1:0] I;

   modport master (output Y, output S, output E, input I);
   modport slave  (input Y, input S, input E, output I);

endinterface

// File: rtl/demux_decoder.sv
// -----------------------------------------------------------------------------
// demux_decoder
// Combinational binary-to-one-hot decoder gated by an enable.
//   sel    : binary lane select (SEL_W bits)
//   en     : enable; 0 forces all outputs low
//   onehot : N_OUT bits, at most one set
// -----------------------------------------------------------------------------
module demux_decoder
   import demux_pkg::*;
#(
   parameter int SEL_W = SEL_W_DEF,
   localparam int N_OUT = n_out(SEL_W)
) (
   input  logic [SEL_W-1:0] sel,
   input  logic             en,
   output logic [N_OUT-1:0] onehot
);

   always_comb begin
      // NOTE: assign a default before any branch so no path leaves the output
      // unassigned; otherwise a latch is inferred.
      onehot = '0;
      // An X/Z select makes every equality unknown, so no bit is set and the
      // output stays all zeros in simulation; synthesis sees a plain decoder.
      for (int k = 0; k < N_OUT; k++) begin
         if (en && (sel == SEL_W'(k))) begin
            onehot[k] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/demultiplexer.sv
// -----------------------------------------------------------------------------
// demultiplexer
// Registered 1-to-N_OUT demultiplexer: on each rising clk edge lane S of I is
// loaded with Y and every other lane with zero (one cycle latency).
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset; clears I
//   bus : demux_if.slave carrying Y, S, E (in) and I (out)
// Build option DEMUX_HOLD_EN: when defined, an edge with E=0 keeps the
// previous I instead of clearing it. Reset clears I in either build.
// -----------------------------------------------------------------------------
module demultiplexer
   import demux_pkg::*;
#(
   parameter int SEL_W  = SEL_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   localparam int N_OUT = n_out(SEL_W)
) (
   input  logic    clk,
   input  logic    rst,
   demux_if.slave  bus
);

   logic [N_OUT-1:0]        lane_sel;
   logic [N_OUT*DATA_W-1:0] lane_d;

   demux_decoder #(
      .SEL_W (SEL_W)
   ) u_decoder (
      .sel    (bus.S),
      .en     (bus.E),
      .onehot (lane_sel)
   );

   // Steer Y onto the decoded lane; the decoder already folds in E, so a
   // disabled cycle produces all-zero next-state data.
   always_comb begin
      lane_d = '0;
      for (int k = 0; k < N_OUT; k++) begin
         lane_d[k*DATA_W +: DATA_W] = lane_sel[k] ? bus.Y : '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignment so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.I <= '0;
      end else begin
`ifdef DEMUX_HOLD_EN
         if (bus.E) begin
            bus.I <= lane_d;
         end
`else
         bus.I <= lane_d;
`endif
      end
   end

endmodule

// File: tb/tb_demultiplexer.sv
// -----------------------------------------------------------------------------
// tb_demultiplexer
// Directed bench for demultiplexer: one DUT at default parameters and one at
// SEL_W=3, DATA_W=4. Expected values are hand-computed constants. Honours
// DEMUX_HOLD_EN for the enable-drop expectation.
// -----------------------------------------------------------------------------
module tb_demultiplexer;

   logic clk;
   logic rst;

   int total = 0;
   int bad   = 0;

   demux_if #(.SEL_W(2), .DATA_W(1)) bus_a ();
   demux_if #(.SEL_W(3), .DATA_W(4)) bus_b ();

   demultiplexer #(.SEL_W(2), .DATA_W(1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a.slave)
   );

   demultiplexer #(.SEL_W(3), .DATA_W(4)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      bus_a.E = 1'b1;
      bus_a.Y = 1'b1;
      bus_a.S = 2'b01;
      bus_b.E = 1'b1;
      bus_b.Y = 4'hF;
      bus_b.S = 3'd2;
      #3;
      total++;
      if (bus_a.I !== 4'b0000) begin
         bad++;
         $display("FAIL reset_a: got %b want 0000", bus_a.I);
      end
      total++;
      if (bus_b.I !== 32'h0) begin
         bad++;
         $display("FAIL reset_b: got %h want 00000000", bus_b.I);
      end
      // Reset held across an edge with E=1 still keeps I at zero.
      step();
      total++;
      if (bus_a.I !== 4'b0000) begin
         bad++;
         $display("FAIL reset_held: got %b want 0000", bus_a.I);
      end
      rst     = 1'b0;
      bus_a.E = 1'b0;
      bus_a.Y = 1'b1;
      bus_a.S = 2'b10;
      bus_b.E = 1'b0;
      for (int n = 0; n < 3; n++) begin
         step();
         total++;
         if (bus_a.I !== 4'b0000) begin
            bad++;
            $display("FAIL disabled_%0d: got %b want 0000", n, bus_a.I);
         end
      end
   endtask

   task automatic test_select_sweep();
      logic [3:0] exp_tab [4];
      exp_tab[0] = 4'b0001;
      exp_tab[1] = 4'b0010;
      exp_tab[2] = 4'b0100;
      exp_tab[3] = 4'b1000;
      bus_a.E = 1'b1;
      bus_a.Y = 1'b1;
      for (int s = 0; s < 4; s++) begin
         bus_a.S = 2'(s);
         step();
         total++;
         if (bus_a.I !== exp_tab[s]) begin
            bad++;
            $display("FAIL sweep_s%0d: got %b want %b", s, bus_a.I, exp_tab[s]);
         end
      end
   endtask

   task automatic test_zero_data();
      bus_a.E = 1'b1;
      bus_a.Y = 1'b0;
      bus_a.S = 2'b11;
      step();
      total++;
      if (bus_a.I !== 4'b0000) begin
         bad++;
         $display("FAIL zero_data: got %b want 0000", bus_a.I);
      end
   endtask

   task automatic test_enable_drop();
      logic [3:0] exp_drop;
`ifdef DEMUX_HOLD_EN
      exp_drop = 4'b0100;
`else
      exp_drop = 4'b0000;
`endif
      bus_a.E = 1'b1;
      bus_a.Y = 1'b1;
      bus_a.S = 2'b10;
      step();
      total++;
      if (bus_a.I !== 4'b0100) begin
         bad++;
         $display("FAIL drop_setup: got %b want 0100", bus_a.I);
      end
      bus_a.E = 1'b0;
      bus_a.S = 2'b01;
      step();
      total++;
      if (bus_a.I !== exp_drop) begin
         bad++;
         $display("FAIL enable_drop: got %b want %b", bus_a.I, exp_drop);
      end
   endtask

   task automatic test_no_comb_path();
      bus_a.E = 1'b1;
      bus_a.Y = 1'b1;
      bus_a.S = 2'b00;
      step();
      // Mid-cycle input changes must not reach I before the next edge.
      bus_a.S = 2'b11;
      #2;
      bus_a.E = 1'b0;
      #1;
      total++;
      if (bus_a.I !== 4'b0001) begin
         bad++;
         $display("FAIL no_comb_path: got %b want 0001", bus_a.I);
      end
   endtask

   task automatic test_async_reset();
      bus_a.E = 1'b1;
      bus_a.Y = 1'b1;
      bus_a.S = 2'b11;
      step();
      total++;
      if (bus_a.I !== 4'b1000) begin
         bad++;
         $display("FAIL async_setup: got %b want 1000", bus_a.I);
      end
      #1;
      rst = 1'b1;
      #1;
      total++;
      if (bus_a.I !== 4'b0000) begin
         bad++;
         $display("FAIL async_clear: got %b want 0000", bus_a.I);
      end
      #1;
      rst     = 1'b0;
      bus_a.S = 2'b01;
      step();
      total++;
      if (bus_a.I !== 4'b0010) begin
         bad++;
         $display("FAIL after_reset: got %b want 0010", bus_a.I);
      end
   endtask

   task automatic test_param();
      bus_b.E = 1'b1;
      bus_b.Y = 4'hA;
      bus_b.S = 3'd5;
      step();
      total++;
      if (bus_b.I !== 32'h00A0_0000) begin
         bad++;
         $display("FAIL param_s5: got %h want 00a00000", bus_b.I);
      end
      bus_b.Y = 4'h3;
      bus_b.S = 3'd7;
      step();
      total++;
      if (bus_b.I !== 32'h3000_0000) begin
         bad++;
         $display("FAIL param_s7: got %h want 30000000", bus_b.I);
      end
      bus_b.Y = 4'hC;
      bus_b.S = 3'd0;
      step();
      total++;
      if (bus_b.I !== 32'h0000_000C) begin
         bad++;
         $display("FAIL param_s0: got %h want 0000000c", bus_b.I);
      end
   endtask

   initial begin
      test_reset();
      test_select_sweep();
      test_zero_data();
      test_enable_drop();
      test_no_comb_path();
      test_async_reset();
      test_param();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/demultiplexer.md
DEMULTIPLEXER -- requirements
Module: demultiplexer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as below.
REQ-002 Parameter `SEL_W`, default 2: select width.
REQ-003 Parameter `DATA_W`, default 1: data width per output lane.
REQ-004 Derived constant `N_OUT` SHALL equal 2**SEL_W (4 by default).
REQ-005 Port `clk`, input, 1 bit: rising-edge clock.
REQ-006 Port `rst`, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port `Y`, input, DATA_W bits: data to route.
REQ-008 Port `S`, input, SEL_W bits: binary lane select.
REQ-009 Port `E`, input, 1 bit: enable, active-high.
REQ-010 Port `I`, output, N_OUT*DATA_W bits: output lanes.
- Lane k occupies bits [k*DATA_W +: DATA_W].
- Default is 4 bits, with lane k at bit k.

Function
REQ-011 `I` SHALL be registered, with a latency of exactly one clk cycle from `Y`/`S`/`E` to `I`.
REQ-012 On a rising clk edge with E=1, the block SHALL load lane S with Y and all other lanes with 0.
REQ-013 On a rising clk edge with E=0 and DEMUX_HOLD_EN undefined, the block SHALL load all of `I` with 0.
REQ-014 With E=1 and Y=0, `I` SHALL become all zeros; there is no distinction from the disabled state.
REQ-015 At most one lane SHALL be non-zero in any cycle (one-hot-or-zero lane activity).
REQ-016 Select values SHALL span exactly 0..N_OUT-1, so no out-of-range select exists.
REQ-017 When S contains X/Z in simulation, `I` SHALL load all zeros; a synthesis-neutral default branch implements this.
REQ-018 Changes on Y/S/E between clock edges SHALL NOT affect `I`; there is no combinational path from input to output.

Reset
REQ-019 Asserting rst SHALL immediately clear `I` to all zeros, independent of clk.
REQ-020 While rst=1, `I` SHALL stay 0 regardless of E/Y/S.
REQ-021 Reset SHALL dominate a simultaneous clock edge.
REQ-022 On the first rising clk edge after rst deasserts, the block SHALL resume normal REQ-012/013 behaviour, with no extra warm-up cycle.
REQ-023 Asserting reset mid-operation SHALL discard the current routing with no residual state.

Configuration
REQ-024 Macro `DEMUX_HOLD_EN` SHALL select the disabled-state behaviour.
- Defined: an edge with E=0 retains the previous `I`. E=1 behaves per REQ-012, and reset still clears.
- Undefined (default build): E=0 clears `I` per REQ-013.
REQ-025 No other behaviour SHALL depend on any macro.

Structure
REQ-026 Shared package `demux_pkg` SHALL hold:
- the default SEL_W and DATA_W constants;
- the `N_OUT` derivation;
- a lane-index typedef (`sel_t`, SEL_W bits).
REQ-027 One sub-module `demux_decoder` SHALL be used: a combinational binary-to-one-hot decoder (SEL_W in, N_OUT out, gated by E).
REQ-028 The top level SHALL combine the decoder output with Y per lane and register the result.
REQ-029 The design SHALL have no other state beyond the `I` register.

Verification
REQ-030 The bench SHALL cover these directed scenarios at default parameters:
- Reset, then disabled: rst=1, then rst=0, E=0, Y=1, S=2'b10 for 3 clocks -> I=4'b0000 throughout.
- Select sweep: E=1, Y=1, S=00, 01, 10, 11 on successive edges -> I=0001, 0010, 0100, 1000, each one cycle after its S.
- Zero data: E=1, Y=0, S=2'b11 -> I=4'b0000 on the next edge.
- Enable drop: I=4'b0100, then E=0 -> I=4'b0000 next edge (default build); I=4'b0100 held with DEMUX_HOLD_EN.
- Async reset: I=4'b1000, rst pulsed mid-cycle (no clk edge) -> I=4'b0000 immediately; first edge after release with E=1, Y=1, S=01 -> I=4'b0010.
- Parameter case: SEL_W=3, DATA_W=4, E=1, Y=4'hA, S=3'd5 -> lane 5 (bits [23:20]) = 4'hA and all other bits 0.
